// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
// Module   : switch_debounce
// Purpose  : Conditions WIDTH asynchronous slide-switch lines. Each line goes
//            through a 2-FF synchroniser and is accepted as a new level only
//            after STABLE_CYCLES consecutive samples that differ from the
//            current debounced level. A one-cycle change strobe with a per-bit
//            mask accompanies every accepted change.
// Ports    : clk          - system clock, rising edge
//            rst_n        - asynchronous active-low reset
//            switch_raw   - raw asynchronous switch levels  [WIDTH]
//            switch_db    - debounced, registered levels    [WIDTH]
//            change_pulse - one-cycle strobe on any switch_db change
//            changed_mask - switch_db bits changed on that edge [WIDTH]
//            stable       - all channels idle and in agreement with input
// Revision : 1.0 - initial release
// ============================================================================
module switch_debounce #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] switch_raw,
    output logic [WIDTH-1:0] switch_db,
    output logic             change_pulse,
    output logic [WIDTH-1:0] changed_mask,
    output logic             stable
);

    localparam int              c_cnt_w    = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_zero = '0;
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STABLE_CYCLES - 1);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_count = 1'b1;

    logic [WIDTH-1:0] w_accept;
    logic [WIDTH-1:0] w_db;
    logic [WIDTH-1:0] w_ch_stable;

    logic             r_change_pulse;
    logic [WIDTH-1:0] r_changed_mask;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            logic               r_sync1;
            logic               r_sync2;
            logic               r_db;
            logic [0:0]         r_state;
            logic [c_cnt_w-1:0] r_cnt;
            logic               w_mismatch;

            assign w_mismatch = (r_sync2 != r_db);

            // With a single-cycle requirement the first mismatching sample
            // is accepted directly from IDLE; otherwise acceptance happens
            // when the run of mismatches reaches its final count.
            assign w_accept[i] = w_mismatch &&
                                 (((r_state == c_st_idle) && (STABLE_CYCLES == 1)) ||
                                  ((r_state == c_st_count) && (r_cnt == c_cnt_last)));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_db    <= 1'b0;
                    r_state <= c_st_idle;
                    r_cnt   <= c_cnt_zero;
                end else begin
                    r_sync1 <= switch_raw[i];
                    r_sync2 <= r_sync1;
                    if (w_accept[i]) begin
                        r_db    <= r_sync2;
                        r_cnt   <= c_cnt_zero;
                        r_state <= c_st_idle;
                    end else if (r_state == c_st_idle) begin
                        if (w_mismatch) begin
                            r_state <= c_st_count;
                            r_cnt   <= c_cnt_one;
                        end
                    end else begin
                        // A matching sample is a bounce: drop the partial run.
                        if (!w_mismatch) begin
                            r_cnt   <= c_cnt_zero;
                            r_state <= c_st_idle;
                        end else begin
                            r_cnt   <= r_cnt + c_cnt_one;
                        end
                    end
                end
            end

            assign w_db[i]        = r_db;
            assign w_ch_stable[i] = (r_cnt == c_cnt_zero) && !w_mismatch;
        end
    endgenerate

    // Strobes are registered so they line up with the switch_db update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_change_pulse <= 1'b0;
            r_changed_mask <= '0;
        end else begin
            r_change_pulse <= |w_accept;
            r_changed_mask <= w_accept;
        end
    end

    assign switch_db    = w_db;
    assign change_pulse = r_change_pulse;
    assign changed_mask = r_changed_mask;
    assign stable       = &w_ch_stable;

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_debounce
// Purpose  : Self-checking bench for switch_debounce (WIDTH=4,
//            STABLE_CYCLES=8). Table vectors, directed corner sequences and
//            randomized stimulus against a run-length reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_switch_debounce;

    localparam int W  = 4;
    localparam int SC = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] switch_raw = '0;
    logic [W-1:0] switch_db;
    logic         change_pulse;
    logic [W-1:0] changed_mask;
    logic         stable;

    switch_debounce #(
        .WIDTH         (W),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .switch_raw   (switch_raw),
        .switch_db    (switch_db),
        .change_pulse (change_pulse),
        .changed_mask (changed_mask),
        .stable       (stable)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per channel, the input two samples back and the
    // length of the current run of samples disagreeing with the debounced level.
    logic [W-1:0] m_h1, m_h2, m_db, m_mask;
    logic         m_pulse, m_stable;
    int           m_run [W];

    // Pulse recorder for directed sequences.
    int           seg_idx;
    int           p_idx  [$];
    logic [W-1:0] p_mask [$];

    typedef struct {
        logic [W-1:0] raw;
        logic [W-1:0] exp_db;
        logic         exp_pulse;
        logic [W-1:0] exp_mask;
        logic         exp_stable;
    } vec_t;

    vec_t vecs [23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_h1 = '0; m_h2 = '0; m_db = '0; m_mask = '0;
        m_pulse = 1'b0; m_stable = 1'b1;
        for (int c = 0; c < W; c++) m_run[c] = 0;
    endtask

    task automatic model_step(input logic [W-1:0] raw);
        logic [W-1:0] acc;
        acc = '0;
        for (int c = 0; c < W; c++) begin
            if (m_h2[c] != m_db[c]) begin
                m_run[c]++;
                if (m_run[c] == SC) begin
                    m_db[c]  = m_h2[c];
                    m_run[c] = 0;
                    acc[c]   = 1'b1;
                end
            end else begin
                m_run[c] = 0;
            end
        end
        m_h2 = m_h1;
        m_h1 = raw;
        m_mask  = acc;
        m_pulse = |acc;
        m_stable = 1'b1;
        for (int c = 0; c < W; c++)
            if (m_run[c] != 0 || m_h2[c] != m_db[c]) m_stable = 1'b0;
    endtask

    task automatic tick(input logic [W-1:0] raw);
        switch_raw = raw;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step(raw);
        #1;
        check("model_db",     32'(switch_db),    32'(m_db));
        check("model_pulse",  32'(change_pulse), 32'(m_pulse));
        check("model_mask",   32'(changed_mask), 32'(m_mask));
        check("model_stable", 32'(stable),       32'(m_stable));
        if (change_pulse) begin
            p_idx.push_back(seg_idx);
            p_mask.push_back(changed_mask);
        end
        seg_idx++;
    endtask

    task automatic clear_rec();
        seg_idx = 0;
        p_idx.delete();
        p_mask.delete();
    endtask

    task automatic ticks(input logic [W-1:0] raw, input int n);
        for (int k = 0; k < n; k++) tick(raw);
    endtask

    initial begin
        model_reset();
        clear_rec();

        // Table: clean rise of bit0 from reset, then a 7-cycle glitch on bit1.
        for (int i = 0; i < 23; i++) begin
            if (i < 11) begin
                int e;
                e = i + 1;
                vecs[i].raw        = 4'h1;
                vecs[i].exp_db     = (e >= 10) ? 4'h1 : 4'h0;
                vecs[i].exp_pulse  = (e == 10);
                vecs[i].exp_mask   = (e == 10) ? 4'h1 : 4'h0;
                vecs[i].exp_stable = !(e >= 2 && e <= 9);
            end else begin
                int g;
                g = i - 11;
                vecs[i].raw        = (g < 7) ? 4'h3 : 4'h1;
                vecs[i].exp_db     = 4'h1;
                vecs[i].exp_pulse  = 1'b0;
                vecs[i].exp_mask   = 4'h0;
                vecs[i].exp_stable = !(g >= 1 && g <= 8);
            end
        end

        // Reset with all switches high.
        rst_n = 1'b0;
        ticks(4'hF, 3);
        check("rst_db",     32'(switch_db),    32'h0);
        check("rst_pulse",  32'(change_pulse), 32'h0);
        check("rst_mask",   32'(changed_mask), 32'h0);
        check("rst_stable", 32'(stable),       32'h1);

        // Release: all four bits accepted at edge 10.
        rst_n = 1'b1;
        ticks(4'hF, 9);
        check("rel_db_edge9", 32'(switch_db), 32'h0);
        tick(4'hF);
        check("rel_db_edge10",    32'(switch_db),    32'hF);
        check("rel_pulse_edge10", 32'(change_pulse), 32'h1);
        check("rel_mask_edge10",  32'(changed_mask), 32'hF);
        tick(4'hF);
        check("rel_pulse_edge11", 32'(change_pulse), 32'h0);

        // Back to zero for the table.
        rst_n = 1'b0;
        tick(4'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 23; i++) begin
            tick(vecs[i].raw);
            check("vec_db",     32'(switch_db),    32'(vecs[i].exp_db));
            check("vec_pulse",  32'(change_pulse), 32'(vecs[i].exp_pulse));
            check("vec_mask",   32'(changed_mask), 32'(vecs[i].exp_mask));
            check("vec_stable", 32'(stable),       32'(vecs[i].exp_stable));
        end

        // 8-cycle pulse on bit1: rise then fall accepted.
        clear_rec();
        ticks(4'h3, 8);
        ticks(4'h1, 20);
        check("w8_count", 32'(p_idx.size()), 32'd2);
        if (p_idx.size() >= 2) begin
            check("w8_rise_idx",  32'(p_idx[0]),  32'd9);
            check("w8_fall_idx",  32'(p_idx[1]),  32'd17);
            check("w8_rise_mask", 32'(p_mask[0]), 32'h2);
            check("w8_fall_mask", 32'(p_mask[1]), 32'h2);
        end

        // Bounce burst on bit2, then settle high.
        clear_rec();
        for (int k = 0; k < 30; k++)
            tick(4'h1 | ((((k / 3) % 2) == 0) ? 4'h4 : 4'h0));
        ticks(4'h5, 20);
        check("burst_count", 32'(p_idx.size()), 32'd1);
        if (p_idx.size() >= 1) begin
            check("burst_idx",  32'(p_idx[0]),  32'd39);
            check("burst_mask", 32'(p_mask[0]), 32'h4);
        end
        ticks(4'h1, 12);

        // Simultaneous rise on bits 2 and 3.
        clear_rec();
        ticks(4'hD, 12);
        check("simul_count", 32'(p_idx.size()), 32'd1);
        if (p_idx.size() >= 1) begin
            check("simul_idx",  32'(p_idx[0]),  32'd9);
            check("simul_mask", 32'(p_mask[0]), 32'hC);
        end
        ticks(4'h1, 12);

        // Staggered by 3 cycles.
        clear_rec();
        ticks(4'h5, 3);
        ticks(4'hD, 12);
        check("stag_count", 32'(p_idx.size()), 32'd2);
        if (p_idx.size() >= 2) begin
            check("stag_idx0",  32'(p_idx[0]),  32'd9);
            check("stag_idx1",  32'(p_idx[1]),  32'd12);
            check("stag_mask0", 32'(p_mask[0]), 32'h4);
            check("stag_mask1", 32'(p_mask[1]), 32'h8);
        end

        // Reset mid-count on bit0.
        ticks(4'h0, 12);
        ticks(4'h1, 5);
        check("mid_stable_pre", 32'(stable), 32'h0);
        rst_n = 1'b0;
        #1;
        check("mid_async_stable", 32'(stable),    32'h1);
        check("mid_async_db",     32'(switch_db), 32'h0);
        tick(4'h1);
        check("mid_rst_db", 32'(switch_db), 32'h0);
        rst_n = 1'b1;
        clear_rec();
        ticks(4'h1, 12);
        check("mid_count", 32'(p_idx.size()), 32'd1);
        if (p_idx.size() >= 1) begin
            check("mid_idx",  32'(p_idx[0]),  32'd9);
            check("mid_mask", 32'(p_mask[0]), 32'h1);
        end

        // Randomized segments against the model.
        for (int s = 0; s < 60; s++) begin
            logic [W-1:0] r;
            int           hold;
            r    = W'($urandom_range(0, 15));
            hold = $urandom_range(1, 12);
            ticks(r, hold);
        end
        ticks(4'h0, 12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
